// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared widths and master FSM state type for the two-slave APB subsystem
package apb_pkg;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** (AW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;
endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - request port bundle between a requester and the APB subsystem
interface apb_if;
  import apb_pkg::*;

  logic          transfer;
  logic          READ_WRITE;
  logic [AW-1:0] apb_read_paddr;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out;

  modport master (
    output transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
    input  apb_read_data_out
  );

  modport slave (
    input  transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
    output apb_read_data_out
  );
endinterface

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - zero-wait-state APB memory slave, cleared by synchronous reset
module apb_mem_slave
  import apb_pkg::*;
(
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-2:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready
);
  logic [DW-1:0] mem [DEPTH];

  // Reset wins over a write landing on the same edge, so an interrupted ACCESS leaves no trace.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (psel && penable && pwrite) begin
      mem[paddr] <= pwdata;
    end
  end

  assign prdata = mem[paddr];
  assign pready = 1'b1;
endmodule

// File: rtl/apb_2slave_top.sv
// rtl/apb_2slave_top.sv - APB master FSM with request latch driving two memory slaves
module apb_2slave_top
  import apb_pkg::*;
(
  input  logic pclk,
  input  logic presetn,
  apb_if.slave req
);
  apb_state_t    state_q, state_d;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          capture;
  logic          sel;
  logic [1:0]    psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] prdata0, prdata1, prdata_sel;
  logic          pready0, pready1, pready_sel;
  logic          complete;

  assign sel        = addr_q[AW-1];
  assign pwrite     = ~rw_q;
  assign prdata_sel = sel ? prdata1 : prdata0;
  assign pready_sel = sel ? pready1 : pready0;
  assign complete   = (state_q == ACCESS) && pready_sel;

  always_comb begin
    state_d = state_q;
    psel    = '0;
    penable = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.transfer) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        psel[sel] = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        psel[sel] = 1'b1;
        penable   = 1'b1;
        // A held transfer chains straight into the next SETUP.
        if (pready_sel) begin
          if (req.transfer) begin
            capture = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        rw_q    <= req.READ_WRITE;
        addr_q  <= req.READ_WRITE ? req.apb_read_paddr : req.apb_write_paddr;
        wdata_q <= req.apb_write_data;
      end
      if (complete && rw_q) begin
        rdata_q <= prdata_sel;
      end
    end
  end

  assign req.apb_read_data_out = rdata_q;

  apb_mem_slave u_slave0 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel[0]),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (addr_q[AW-2:0]),
    .pwdata  (wdata_q),
    .prdata  (prdata0),
    .pready  (pready0)
  );

  apb_mem_slave u_slave1 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel[1]),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (addr_q[AW-2:0]),
    .pwdata  (wdata_q),
    .prdata  (prdata1),
    .pready  (pready1)
  );
endmodule

// File: tb/tb_apb_2slave_top.sv
// tb/tb_apb_2slave_top.sv - randomized self-checking bench for apb_2slave_top
module tb_apb_2slave_top;
  import apb_pkg::*;

  logic pclk = 1'b0;
  logic presetn;

  apb_if bus ();

  apb_2slave_top dut (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (bus)
  );

  always #5 pclk = ~pclk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Flat 512-entry memory: the full address picks the word, slave split is implicit.
  logic [DW-1:0] ref_mem [2*DEPTH];
  logic [DW-1:0] ref_rd;

  function automatic void model_reset();
    for (int i = 0; i < 2*DEPTH; i++) ref_mem[i] = '0;
    ref_rd = '0;
  endfunction

  function automatic void model_apply(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (rw) ref_rd = ref_mem[a];
    else    ref_mem[a] = d;
  endfunction

  // The unused address port gets noise so a wrong address select shows up.
  task automatic set_req(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.READ_WRITE     = rw;
    bus.apb_write_data = d;
    if (rw) begin
      bus.apb_read_paddr  = a;
      bus.apb_write_paddr = AW'($urandom);
    end else begin
      bus.apb_write_paddr = a;
      bus.apb_read_paddr  = AW'($urandom);
    end
  endtask

  task automatic do_xfer(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(rw, a, d);
    bus.transfer = 1'b1;
    @(posedge pclk);
    #1 bus.transfer = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #1 model_apply(rw, a, d);
  endtask

  task automatic do_reset(input int cycles);
    presetn = 1'b1;
    repeat (cycles) @(posedge pclk);
    #1 presetn = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [AW-1:0] a;
    do_reset(2);
    tests_run++;
    if (bus.apb_read_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h expected 00", bus.apb_read_data_out);
    end
    for (int i = 0; i < 4; i++) begin
      bus.apb_write_data = 8'hFF;
      a = AW'($urandom);
      do_xfer(1'b1, a, 8'h00);
      tests_run++;
      if (bus.apb_read_data_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_mem_read addr=%h: got %h expected 00", a, bus.apb_read_data_out);
      end
    end
  endtask

  task automatic test_write_read();
    do_xfer(1'b0, 9'h0A5, 8'h3C);
    do_xfer(1'b0, 9'h0A6, 8'hC3);
    tests_run++;
    if (bus.apb_read_data_out !== ref_rd) begin
      tests_failed++;
      $display("FAIL hold_over_write: got %h expected %h", bus.apb_read_data_out, ref_rd);
    end
    set_req(1'b1, 9'h0A5, 8'h00);
    bus.transfer = 1'b1;
    @(posedge pclk);
    #1 bus.transfer = 1'b0;
    @(posedge pclk);
    #1;
    tests_run++;
    if (bus.apb_read_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL read_too_early: got %h expected 00", bus.apb_read_data_out);
    end
    @(posedge pclk);
    #1 model_apply(1'b1, 9'h0A5, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'h3C) begin
      tests_failed++;
      $display("FAIL write_read_0a5: got %h expected 3c", bus.apb_read_data_out);
    end
    do_xfer(1'b1, 9'h0A6, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'hC3) begin
      tests_failed++;
      $display("FAIL write_read_0a6: got %h expected c3", bus.apb_read_data_out);
    end
  endtask

  task automatic test_decode();
    do_xfer(1'b0, 9'h010, 8'h11);
    do_xfer(1'b0, 9'h110, 8'h22);
    do_xfer(1'b1, 9'h010, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'h11) begin
      tests_failed++;
      $display("FAIL decode_slave0: got %h expected 11", bus.apb_read_data_out);
    end
    do_xfer(1'b1, 9'h110, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'h22) begin
      tests_failed++;
      $display("FAIL decode_slave1: got %h expected 22", bus.apb_read_data_out);
    end
  endtask

  task automatic test_back_to_back(input int n_writes);
    bit            rw [16];
    logic [AW-1:0] a  [16];
    logic [DW-1:0] d  [16];
    int            n;
    n = 2 * n_writes;
    for (int k = 0; k < n_writes; k++) begin
      rw[k] = 1'b0;
      a[k]  = AW'($urandom);
      d[k]  = DW'($urandom_range(1, 255));
      rw[k + n_writes] = 1'b1;
      a[k + n_writes]  = a[k];
      d[k + n_writes]  = DW'($urandom);
    end
    set_req(rw[0], a[0], d[0]);
    bus.transfer = 1'b1;
    @(posedge pclk);
    for (int k = 0; k < n; k++) begin
      @(posedge pclk);
      #1;
      tests_run++;
      if (bus.apb_read_data_out !== ref_rd) begin
        tests_failed++;
        $display("FAIL b2b_mid_hold k=%0d: got %h expected %h", k, bus.apb_read_data_out, ref_rd);
      end
      if (k < n - 1) set_req(rw[k+1], a[k+1], d[k+1]);
      else           bus.transfer = 1'b0;
      @(posedge pclk);
      #1 model_apply(rw[k], a[k], d[k]);
      tests_run++;
      if (bus.apb_read_data_out !== ref_rd) begin
        tests_failed++;
        $display("FAIL b2b_complete k=%0d addr=%h: got %h expected %h", k, a[k], bus.apb_read_data_out, ref_rd);
      end
    end
  endtask

  task automatic test_input_change();
    set_req(1'b0, 9'h0C3, 8'h5A);
    bus.transfer = 1'b1;
    @(posedge pclk);
    #1 bus.transfer = 1'b0;
    bus.READ_WRITE      = 1'b1;
    bus.apb_write_paddr = 9'h0C4;
    bus.apb_read_paddr  = 9'h0C3;
    bus.apb_write_data  = 8'h99;
    @(posedge pclk);
    #1 bus.apb_write_paddr = 9'h1C3;
    bus.apb_write_data = 8'h77;
    @(posedge pclk);
    #1 model_apply(1'b0, 9'h0C3, 8'h5A);
    tests_run++;
    if (bus.apb_read_data_out !== ref_rd) begin
      tests_failed++;
      $display("FAIL latch_no_read: got %h expected %h", bus.apb_read_data_out, ref_rd);
    end
    do_xfer(1'b1, 9'h0C3, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'h5A) begin
      tests_failed++;
      $display("FAIL latch_orig_addr: got %h expected 5a", bus.apb_read_data_out);
    end
    do_xfer(1'b1, 9'h0C4, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== ref_rd) begin
      tests_failed++;
      $display("FAIL latch_new_addr: got %h expected %h", bus.apb_read_data_out, ref_rd);
    end
    do_xfer(1'b1, 9'h1C3, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== ref_rd) begin
      tests_failed++;
      $display("FAIL latch_late_addr: got %h expected %h", bus.apb_read_data_out, ref_rd);
    end
  endtask

  task automatic test_reset_mid();
    do_xfer(1'b0, 9'h155, 8'h6B);
    do_xfer(1'b1, 9'h155, 8'h00);
    set_req(1'b0, 9'h055, 8'hFF);
    bus.transfer = 1'b1;
    @(posedge pclk);
    @(posedge pclk);
    #1 presetn = 1'b1;
    @(posedge pclk);
    #1 presetn = 1'b0;
    bus.transfer = 1'b0;
    model_reset();
    tests_run++;
    if (bus.apb_read_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_rdata: got %h expected 00", bus.apb_read_data_out);
    end
    do_xfer(1'b1, 9'h055, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_nowrite: got %h expected 00", bus.apb_read_data_out);
    end
    do_xfer(1'b0, 9'h055, 8'hA7);
    do_xfer(1'b1, 9'h055, 8'h00);
    tests_run++;
    if (bus.apb_read_data_out !== 8'hA7) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: got %h expected a7", bus.apb_read_data_out);
    end
  endtask

  task automatic test_random(input int n);
    bit            rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      rw = ($urandom_range(0, 2) == 0);
      a  = (rw || $urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7) * 64) : AW'($urandom);
      d  = DW'($urandom);
      do_xfer(rw, a, d);
      tests_run++;
      if (bus.apb_read_data_out !== ref_rd) begin
        tests_failed++;
        $display("FAIL random i=%0d rw=%0d addr=%h: got %h expected %h", i, rw, a, bus.apb_read_data_out, ref_rd);
      end
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end
  endtask

  initial begin
    presetn             = 1'b1;
    bus.transfer        = 1'b0;
    bus.READ_WRITE      = 1'b0;
    bus.apb_read_paddr  = '0;
    bus.apb_write_paddr = '0;
    bus.apb_write_data  = '0;
    model_reset();
    @(posedge pclk);
    #1;
    test_reset();
    test_write_read();
    test_decode();
    test_back_to_back(4);
    test_back_to_back(6);
    test_input_change();
    test_reset_mid();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
